// File: rtl/serial_deserializer_if.sv
// rtl/serial_deserializer_if.sv - Serial receive line and word output handshake bundle
interface serial_deserializer_if #(
    parameter int WORD_LENGTH = 16
);
    logic                   enable_i;
    logic                   bit_valid_i;
    logic                   serial_data_i;
    logic                   frame_sync_i;
    logic                   clip_num_i;
    logic                   data_ready_i;
    logic                   clear_overrun_i;
    logic [WORD_LENGTH-1:0] data_o;
    logic                   clip_o;
    logic                   data_valid_o;
    logic                   done_o;
    logic                   overrun_o;

    modport master (
        output enable_i, bit_valid_i, serial_data_i, frame_sync_i,
               clip_num_i, data_ready_i, clear_overrun_i,
        input  data_o, clip_o, data_valid_o, done_o, overrun_o
    );

    modport slave (
        input  enable_i, bit_valid_i, serial_data_i, frame_sync_i,
               clip_num_i, data_ready_i, clear_overrun_i,
        output data_o, clip_o, data_valid_o, done_o, overrun_o
    );
endinterface

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - MSB-first serial to word deserializer with clip tag and valid/ready output
module serial_deserializer #(
    parameter int WORD_LENGTH = 16,
    parameter bit CLIP_TOGGLE = 1'b1
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    serial_deserializer_if.slave bus
);
    localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_LENGTH - 1);
    localparam logic [CW-1:0] CNT_FS   = CW'(WORD_LENGTH - 2);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic [WORD_LENGTH-1:0] r_shift;
    logic                   r_toggle;
    logic [WORD_LENGTH-1:0] r_data;
    logic                   r_clip;
    logic                   r_valid;
    logic                   r_done;
    logic                   r_overrun;

    logic                   w_strobe;
    logic                   w_complete;
    logic                   w_load;
    logic                   w_tag;
    logic [WORD_LENGTH-1:0] w_word;

    assign w_strobe   = (r_state == S_SHIFT) && bus.enable_i && bus.bit_valid_i;
    assign w_complete = w_strobe && !bus.frame_sync_i && (r_count == '0);
    // A completed word may replace the held one when the consumer takes it in the same cycle.
    assign w_load     = w_complete && (!r_valid || bus.data_ready_i);
    assign w_tag      = CLIP_TOGGLE ? r_toggle : bus.clip_num_i;
    assign w_word     = {r_shift[WORD_LENGTH-2:0], bus.serial_data_i};

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= S_IDLE;
            r_count   <= CNT_LAST;
            r_shift   <= '0;
            r_toggle  <= 1'b0;
            r_data    <= '0;
            r_clip    <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= w_complete;

            if (w_load) begin
                r_data  <= w_word;
                r_clip  <= w_tag;
                r_valid <= 1'b1;
            end else if (r_valid && bus.data_ready_i) begin
                r_valid <= 1'b0;
            end

            if (w_complete && !w_load) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_overrun_i) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_count  <= CNT_LAST;
                    r_shift  <= '0;
                    r_toggle <= 1'b0;
                    if (bus.enable_i) begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!bus.enable_i) begin
                        r_state  <= S_IDLE;
                        r_count  <= CNT_LAST;
                        r_shift  <= '0;
                        r_toggle <= 1'b0;
                    end else if (bus.bit_valid_i) begin
                        if (bus.frame_sync_i) begin
                            r_shift  <= {{(WORD_LENGTH-1){1'b0}}, bus.serial_data_i};
                            r_count  <= CNT_FS;
                            r_toggle <= 1'b0;
                        end else begin
                            r_shift <= w_word;
                            if (r_count == '0) begin
                                r_count  <= CNT_LAST;
                                r_toggle <= ~r_toggle;
                            end else begin
                                r_count <= r_count - 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_o       = r_data;
    assign bus.clip_o       = r_clip;
    assign bus.data_valid_o = r_valid;
    assign bus.done_o       = r_done;
    assign bus.overrun_o    = r_overrun;
endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - Directed self-checking bench for serial_deserializer
module tb_serial_deserializer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   done_cnt;
    int   d0;

    serial_deserializer_if #(.WORD_LENGTH(16)) bus ();

    serial_deserializer #(.WORD_LENGTH(16), .CLIP_TOGGLE(1'b1)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done_o === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        bus.bit_valid_i   = 1'b1;
        bus.serial_data_i = b;
        bus.frame_sync_i  = fs;
        tick();
        bus.bit_valid_i   = 1'b0;
        bus.frame_sync_i  = 1'b0;
    endtask

    task automatic send_range(input logic [15:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_range(w, 15, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        bus.enable_i        = 1'b0;
        bus.bit_valid_i     = 1'b0;
        bus.serial_data_i   = 1'b0;
        bus.frame_sync_i    = 1'b0;
        bus.clip_num_i      = 1'b0;
        bus.data_ready_i    = 1'b0;
        bus.clear_overrun_i = 1'b0;
        repeat (3) tick();
        check_eq("rst_data",    32'(bus.data_o), 32'h0);
        check_eq("rst_clip",    32'(bus.clip_o), 32'h0);
        check_eq("rst_valid",   32'(bus.data_valid_o), 32'h0);
        check_eq("rst_done",    32'(bus.done_o), 32'h0);
        check_eq("rst_overrun", 32'(bus.overrun_o), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single word with consumer ready
        bus.enable_i     = 1'b1;
        bus.data_ready_i = 1'b1;
        tick();
        send_range(16'hA5C3, 15, 1);
        check_eq("w1_done_early",  32'(bus.done_o), 32'h0);
        check_eq("w1_valid_early", 32'(bus.data_valid_o), 32'h0);
        send_range(16'hA5C3, 0, 0);
        check_eq("w1_done",  32'(bus.done_o), 32'h1);
        check_eq("w1_valid", 32'(bus.data_valid_o), 32'h1);
        check_eq("w1_data",  32'(bus.data_o), 32'hA5C3);
        check_eq("w1_clip",  32'(bus.clip_o), 32'h0);
        tick();
        check_eq("w1_done_pulse", 32'(bus.done_o), 32'h0);
        check_eq("w1_valid_clr",  32'(bus.data_valid_o), 32'h0);
        check_eq("w1_done_cnt",   32'(done_cnt), 32'd1);

        // Overrun with consumer stalled
        bus.data_ready_i = 1'b0;
        send_word(16'h1234);
        check_eq("w2_data",    32'(bus.data_o), 32'h1234);
        check_eq("w2_clip",    32'(bus.clip_o), 32'h1);
        check_eq("w2_valid",   32'(bus.data_valid_o), 32'h1);
        check_eq("w2_overrun", 32'(bus.overrun_o), 32'h0);
        send_word(16'hBEEF);
        check_eq("w3_done",    32'(bus.done_o), 32'h1);
        check_eq("w3_data",    32'(bus.data_o), 32'h1234);
        check_eq("w3_clip",    32'(bus.clip_o), 32'h1);
        check_eq("w3_overrun", 32'(bus.overrun_o), 32'h1);
        bus.clear_overrun_i = 1'b1;
        tick();
        bus.clear_overrun_i = 1'b0;
        check_eq("clr_overrun", 32'(bus.overrun_o), 32'h0);
        check_eq("clr_valid",   32'(bus.data_valid_o), 32'h1);

        // Ready only in the completion cycle replaces the held word
        send_range(16'hBEEF, 15, 1);
        bus.data_ready_i = 1'b1;
        send_range(16'hBEEF, 0, 0);
        check_eq("w4_valid",   32'(bus.data_valid_o), 32'h1);
        check_eq("w4_data",    32'(bus.data_o), 32'hBEEF);
        check_eq("w4_clip",    32'(bus.clip_o), 32'h1);
        check_eq("w4_overrun", 32'(bus.overrun_o), 32'h0);
        tick();
        check_eq("w4_valid_clr", 32'(bus.data_valid_o), 32'h0);

        // Frame sync restarts a partial word
        d0 = done_cnt;
        send_range(16'h0016, 4, 0);
        send_bit(1'b1, 1'b1);
        check_eq("fs_done_none", 32'(bus.done_o), 32'h0);
        send_range(16'h0001, 14, 0);
        check_eq("fs_data", 32'(bus.data_o), 32'h8001);
        check_eq("fs_clip", 32'(bus.clip_o), 32'h0);
        tick();
        check_eq("fs_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Enable drop discards partial; strobes in IDLE are ignored
        send_range(16'h007F, 6, 0);
        bus.enable_i = 1'b0;
        tick();
        send_bit(1'b1, 1'b0);
        bus.enable_i = 1'b1;
        tick();
        send_word(16'h00FF);
        check_eq("en_data", 32'(bus.data_o), 32'h00FF);
        check_eq("en_clip", 32'(bus.clip_o), 32'h0);
        tick();

        // Clip tag alternates across back-to-back words
        bus.enable_i = 1'b0;
        tick();
        bus.enable_i = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            send_word(16'h1000 + 16'(k));
            check_eq($sformatf("seq%0d_data", k), 32'(bus.data_o), 32'h1000 + 32'(k));
            check_eq($sformatf("seq%0d_clip", k), 32'(bus.clip_o), 32'(k & 1));
        end

        // Asynchronous reset mid-word with a held word and overrun
        bus.data_ready_i = 1'b0;
        tick();
        send_word(16'h5555);
        send_word(16'hAAAA);
        check_eq("pre_rst_overrun", 32'(bus.overrun_o), 32'h1);
        check_eq("pre_rst_valid",   32'(bus.data_valid_o), 32'h1);
        send_range(16'h00FF, 15, 11);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_data",    32'(bus.data_o), 32'h0);
        check_eq("arst_clip",    32'(bus.clip_o), 32'h0);
        check_eq("arst_valid",   32'(bus.data_valid_o), 32'h0);
        check_eq("arst_done",    32'(bus.done_o), 32'h0);
        check_eq("arst_overrun", 32'(bus.overrun_o), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.data_ready_i = 1'b1;
        send_word(16'h0003);
        check_eq("post_rst_data", 32'(bus.data_o), 32'h0003);
        check_eq("post_rst_clip", 32'(bus.clip_o), 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
